aes_core_arbiter: RTL and testbench
===================================

AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16, cycles the shared combinational AES core is given to settle after its input register loads; legal range 1..65535.
REQ-002 Parameter DATA_W, default 128, block width in bits.
REQ-003 clk  input  1  system clock; one clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  2  per-requester level request; bit i belongs to requester i.
REQ-006 data0  input  DATA_W  plaintext block of requester 0; sampled only on its grant edge.
REQ-007 data1  input  DATA_W  plaintext block of requester 1; sampled only on its grant edge.
REQ-008 ack  output  2  one-cycle pulse on bit i: requester i's block accepted.
REQ-009 done  output  2  one-cycle pulse on bit i: result for requester i valid on result.
REQ-010 result  output  DATA_W  registered ciphertext of the most recently completed job.
REQ-011 busy  output  1  high while a job owns the core.
REQ-012 core_data  output  DATA_W  registered input to the shared AES core.
REQ-013 core_result  input  DATA_W  combinational output of the shared AES core.

Function
REQ-014 FSM states IDLE and SETTLE only; busy = (state == SETTLE).
REQ-015 IDLE with req == 0: remain in IDLE; ack, done = 0.
REQ-016 IDLE with any req bit set at edge E: grant exactly one requester, load its data into core_data, pulse its ack bit in the cycle after E, clear the settle counter, enter SETTLE.
REQ-017 Arbitration round-robin: single requester is always granted; with req == 2'b11, the requester not granted last wins.
REQ-018 last-granted pointer updates only on a grant.
REQ-019 SETTLE: counter increments each cycle; at the edge where counter == SETTLE_CYCLES-1, capture core_result into result, pulse done for the owner, return to IDLE.
REQ-020 Latency: ack edge E to done edge E+SETTLE_CYCLES exactly.
REQ-021 Requests arriving during SETTLE are not granted; they are granted no earlier than the edge after done.
REQ-022 A requester holding req high after its ack is treated as a new request; requesters deassert req in the ack cycle.
REQ-023 core_data holds stable throughout SETTLE and until the next grant.
REQ-024 result holds its value between done pulses; ack and done never assert in the same cycle.
REQ-025 Settle counter width is $clog2(SETTLE_CYCLES+1); no wrap occurs in legal operation.

Reset
REQ-026 rst high at an edge: state IDLE; ack, done = 0; result, core_data = 0; counter = 0; last-granted pointer = 1 (requester 0 wins the first tie).
REQ-027 rst during SETTLE aborts the job: no done is emitted and the aborted requester must re-request.
REQ-028 rst takes priority over every simultaneous event.

Structure
REQ-029 Package aes_ctrl_pkg holds the FSM state type, AES_BLOCK_W = 128 and DEFAULT_SETTLE_CYCLES = 16.
REQ-030 One sub-module, rr_arb2: two-input round-robin arbiter with the pointer and a one-hot grant output.
REQ-031 The AES core is instantiated outside this block, with its key fixed at the core.

Verification
REQ-032 Single request: SETTLE_CYCLES=16, bench core is real AES with key 5468617473206d79204b756e67204675; req0 pulse with data0 = 54776f204f6e65204e696e652054776f -> ack[0] at E, done[0] at E+16, result 29c3505f571420f6402299b31a02d73a.
REQ-033 Simultaneous requests: req = 2'b11 after reset -> requester 0 served first; requester 1 ack'd on the edge after done[0], with its own correct ciphertext.
REQ-034 Fairness: both req held high for 6 jobs -> grants alternate 0,1,0,1,0,1, with no consecutive double grant.
REQ-035 Request during SETTLE: req1 rises 3 cycles after ack[0] -> no ack[1] until the cycle after done[0]; core_data unchanged during SETTLE.
REQ-036 Reset mid-job: rst asserted 5 cycles after ack -> done stays 0, busy = 0, result = 0; next req1 completes normally.
REQ-037 Boundary: SETTLE_CYCLES=1 -> done one cycle after ack; back-to-back jobs complete every 2 cycles.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES core arbiter.
package aes_ctrl_pkg;

  localparam int unsigned AES_BLOCK_W           = 128;
  localparam int unsigned DEFAULT_SETTLE_CYCLES = 16;

  // IDLE waits for a request; SETTLE owns the shared core until its output is stable.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } aes_state_e;

endpackage

// File: rtl/aes_core_arbiter_rr_arb2.sv
// Two-input round-robin arbiter with a last-granted pointer and one-hot grant.
module rr_arb2
  import aes_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_grant
);

  // 1 means requester 1 was granted last, so requester 0 wins the next tie.
  logic r_last;

  // Grant: a lone requester always wins; a tie goes to the one not granted last.
  always_comb begin
    o_grant = '0;
    if (i_en) begin
      case (i_req)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
        default: o_grant = '0;
      endcase
    end
  end

  // Pointer: moves only when a grant is actually issued.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= 1'b1;
    end else if (|o_grant) begin
      r_last <= o_grant[1];
    end
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one combinational AES core between two requesters: grants one job at a
// time, registers its block into the core, waits SETTLE_CYCLES, captures the result.
module aes_core_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int unsigned DATA_W        = AES_BLOCK_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic [1:0]        ack,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic [DATA_W-1:0] core_data,
  input  logic [DATA_W-1:0] core_result
);

  localparam int unsigned      CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  aes_state_e       r_state;
  aes_state_e       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_owner;
  logic [1:0]       w_grant;
  logic             w_arb_en;
  logic             w_load;
  logic             w_finish;

  rr_arb2 u_arb (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .i_en    (w_arb_en),
    .o_grant (w_grant)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: leave IDLE on any request, leave SETTLE on the last settle cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (|req)              w_next_state = ST_SETTLE;
      ST_SETTLE: if (r_cnt == CNT_LAST) w_next_state = ST_IDLE;
      default:                          w_next_state = ST_IDLE;
    endcase
  end

  // State decode: arbitration only runs in IDLE, so SETTLE-time requests wait.
  always_comb begin
    w_arb_en = (r_state == ST_IDLE);
    w_load   = |w_grant;
    w_finish = (r_state == ST_SETTLE) && (r_cnt == CNT_LAST);
    busy     = (r_state == ST_SETTLE);
  end

  // Datapath: ack/done are registered one-cycle pulses; core_data only moves on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack       <= '0;
      done      <= '0;
      result    <= '0;
      core_data <= '0;
      r_cnt     <= '0;
      r_owner   <= 1'b0;
    end else begin
      ack  <= w_grant;
      done <= '0;
      if (w_load) begin
        core_data <= w_grant[1] ? data1 : data0;
        r_owner   <= w_grant[1];
        r_cnt     <= '0;
      end else if (r_state == ST_SETTLE) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (w_finish) begin
        result <= core_result;
        done   <= r_owner ? 2'b10 : 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: two instances (settle 16 and settle 1) each driven
// by randomized requesters, with a real AES-128 model standing in for the core.
module tb_aes_core_arbiter;

  localparam logic [127:0] AES_KEY = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] KAT_PT  = 128'h54776f204f6e65204e696e652054776f;
  localparam logic [127:0] KAT_CT  = 128'h29c3505f571420f6402299b31a02d73a;

  typedef struct {
    bit           id;
    logic [127:0] res;
    bit           kat;
  } exp_t;

  logic        clk = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t = {v, v} << n;
    return t[15:8];
  endfunction

  // S-box from first principles: multiplicative inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv  = 8'h01;
    logic [7:0] base = x;
    logic [7:0] e    = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tw;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] k = AES_KEY;
    logic [127:0] out = '0;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {tw[23:0], tw[31:24]};
        tw = {sbox(tw[31:24]), sbox(tw[23:16]), sbox(tw[15:8]), sbox(tw[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int i = 0; i < 16; i++) begin
      tw   = w[i/4];
      s[i] = pt[127-8*i -: 8] ^ tw[31-8*(i%4) -: 8];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox(s[i]);
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr + 4*c] = s[rr + 4*((c + rr) % 4)];
      s = t;
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) begin
        tw   = w[4*r + i/4];
        s[i] = s[i] ^ tw[31-8*(i%4) -: 8];
      end
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  function automatic logic [127:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input int unsigned s, input string nm,
                     input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL S=%0d %s actual=%h expected=%h", s, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned S = (g == 0) ? 32'd16 : 32'd1;

    logic         rst;
    logic [1:0]   req;
    logic [127:0] d0, d1;
    logic [1:0]   ack, done;
    logic [127:0] result, core_data, core_result;
    logic         busy;
    bit           fin = 1'b0;
    bit           drained = 1'b0;
    bit           hold = 1'b0;
    int unsigned  acks = 0;
    logic [1:0]   last_ack = '0;
    exp_t         q[$];

    aes_core_arbiter #(.SETTLE_CYCLES(S), .DATA_W(128)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .data0       (d0),
      .data1       (d1),
      .ack         (ack),
      .done        (done),
      .result      (result),
      .busy        (busy),
      .core_data   (core_data),
      .core_result (core_result)
    );

    assign core_result = aes_enc(core_data);

    // Reference model: one job at a time, done exactly S edges after the grant edge.
    initial begin : model
      bit           p_rst = 1'b1;
      logic [1:0]   p_req = '0;
      logic [127:0] p_d0 = '0, p_d1 = '0;
      bit           m_active = 1'b0, m_last = 1'b1, m_owner = 1'b0;
      int unsigned  m_left = 0;
      logic [127:0] m_core = '0;
      logic [1:0]   e_ack, e_done;
      forever begin
        @(negedge clk);
        e_ack = '0;
        e_done = '0;
        if (p_rst) begin
          m_active = 1'b0; m_last = 1'b1; m_core = '0;
          q.delete();
        end else if (m_active) begin
          m_left--;
          if (m_left == 0) begin
            e_done[m_owner] = 1'b1;
            m_active = 1'b0;
          end
        end else if (p_req != 2'b00) begin
          m_owner = (p_req == 2'b11) ? !m_last : p_req[1];
          m_last = m_owner;
          e_ack[m_owner] = 1'b1;
          m_active = 1'b1;
          m_left = S;
          m_core = m_owner ? p_d1 : p_d0;
          q.push_back('{id: m_owner, res: aes_enc(m_core), kat: (m_core == KAT_PT)});
        end
        chk(S, "ack", 128'(ack), 128'(e_ack));
        chk(S, "done", 128'(done), 128'(e_done));
        chk(S, "busy", 128'(busy), 128'(m_active));
        chk(S, "core_data", core_data, m_core);
        p_rst = rst; p_req = req; p_d0 = d0; p_d1 = d1;
      end
    end

    // Monitor: pops the scoreboard on every done pulse; result must hold otherwise.
    initial begin : monitor
      bit           h_rst = 1'b1;
      logic [127:0] h_res = '0;
      exp_t         e;
      forever begin
        @(negedge clk);
        if (h_rst) begin
          h_res = '0;
        end else if (done != 2'b00) begin
          if (q.size() == 0) begin
            chk(S, "done_unexpected", 128'(done), 128'(0));
          end else begin
            e = q.pop_front();
            chk(S, "done_id", 128'(done), e.id ? 128'(2'b10) : 128'(2'b01));
            chk(S, "result", result, e.res);
            if (e.kat) chk(S, "kat_result", result, KAT_CT);
            h_res = e.res;
          end
        end
        chk(S, "result_hold", result, h_res);
        if (fin && !drained) begin
          chk(S, "queue_empty", 128'(q.size()), 128'(0));
          drained = 1'b1;
        end
        h_rst = rst;
      end
    end

    task automatic timeout(input string nm);
      $display("FAIL S=%0d timeout_%s actual=no_event expected=event", S, nm);
      $fatal(1, "bench stalled");
    endtask

    // One clock; requesters drop req in their ack cycle unless deliberately holding.
    task automatic tick();
      @(posedge clk);
      #1;
      last_ack = ack;
      acks += $countones(ack);
      if (hold) begin
        if (ack[0]) d0 = rnd();
        if (ack[1]) d1 = rnd();
      end else begin
        req = req & ~ack;
      end
    endtask

    task automatic wait_ack(input int i, input int unsigned lim);
      for (int n = 0; n < lim; n++) begin
        tick();
        if (last_ack[i]) return;
      end
      timeout("ack");
    endtask

    task automatic wait_idle(input int unsigned lim);
      for (int n = 0; n < lim; n++) begin
        tick();
        if (req == 2'b00 && !busy) begin
          tick();
          return;
        end
      end
      timeout("idle");
    endtask

    initial begin : drive
      int unsigned base;
      rst = 1'b1; req = '0; d0 = '0; d1 = '0;
      repeat (3) tick();
      rst = 1'b0;
      // Known-answer job on requester 0.
      d0 = KAT_PT; req = 2'b01;
      wait_idle(S + 20);
      // Tie straight after reset: requester 0 first, then 1.
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      d0 = rnd(); d1 = rnd(); req = 2'b11;
      wait_idle(2*S + 20);
      // Both held high for six jobs.
      d0 = rnd(); d1 = rnd(); hold = 1'b1; req = 2'b11; base = acks;
      for (int n = 0; n < 6*(S+1) + 10; n++) begin
        tick();
        if (acks >= base + 6) break;
      end
      if (acks < base + 6) timeout("fairness");
      hold = 1'b0; req = '0;
      wait_idle(S + 20);
      // Requester 1 arrives while requester 0 settles.
      d0 = rnd(); req = 2'b01;
      wait_ack(0, 10);
      repeat (3) tick();
      d1 = rnd(); req[1] = 1'b1;
      wait_idle(2*S + 20);
      // Reset five cycles into a job, then a clean job.
      d1 = rnd(); req = 2'b10;
      wait_ack(1, 10);
      repeat (5) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      d1 = rnd(); req = 2'b10;
      wait_idle(S + 20);
      // Random traffic with occasional resets.
      for (int n = 0; n < ((S > 1) ? 1500 : 600); n++) begin
        if ($urandom_range(0, 399) == 0) begin
          rst = 1'b1; tick(); rst = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
          if (!req[i] && $urandom_range(0, 3) == 0) begin
            if (i == 0) d0 = rnd(); else d1 = rnd();
            req[i] = 1'b1;
          end
        end
        tick();
      end
      wait_idle(2*S + 20);
      fin = 1'b1;
    end
  end

  initial begin : finish_ctl
    while (!(g_inst[0].drained && g_inst[1].drained)) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
